stream_bit_reverse: RTL and testbench



---
 rtl/stream_bit_reverse.sv | 143 ++++++++++++++
 tb/tb_stream_bit_reverse.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bit_reverse.sv
// stream_bit_reverse: two-stage pipelined valid/ready stream that applies a per-beat
// transform (pass, full-word bit reverse, byte swap, or bit reverse within each byte).
// S1 captures the incoming beat and its mode; S2 holds the transformed beat and drives out_*.
// Optional statistics counters (stat_clr/stat_beats/stat_pkts) are built only when the
// macro STREAM_BIT_REVERSE_STATS_EN is defined.
module stream_bit_reverse #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last
`ifdef STREAM_BIT_REVERSE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_pkts
`endif
);

    // Reject widths that cannot be split into whole bytes, and any override of KEEP_W.
    if (((DATA_W % 8) != 0) || (DATA_W < 8)) begin : g_bad_data_w
        $error("stream_bit_reverse: DATA_W must be a multiple of 8 and at least 8");
    end
    if (KEEP_W != DATA_W / 8) begin : g_bad_keep_w
        $error("stream_bit_reverse: KEEP_W is derived from DATA_W and must not be overridden");
    end

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [KEEP_W-1:0] s1_keep;
    logic              s1_last;
    logic [1:0]        s1_mode;

    logic              s2_load;
    logic              s1_adv;
    logic [DATA_W-1:0] xf_data;
    logic [KEEP_W-1:0] xf_keep;

    // S2 may load when empty or draining; S1 may advance when empty or when S2 takes its beat.
    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_load;
    assign in_ready = !s1_valid || !out_valid || out_ready;

    // Transform the S1 beat according to the mode captured alongside it.
    always_comb begin
        xf_data = s1_data;
        xf_keep = s1_keep;
        case (s1_mode)
            2'b01: begin
                for (int i = 0; i < DATA_W; i++) begin
                    xf_data[i] = s1_data[DATA_W-1-i];
                end
                for (int j = 0; j < KEEP_W; j++) begin
                    xf_keep[j] = s1_keep[KEEP_W-1-j];
                end
            end
            2'b10: begin
                for (int j = 0; j < KEEP_W; j++) begin
                    xf_data[8*j +: 8] = s1_data[8*(KEEP_W-1-j) +: 8];
                    xf_keep[j]        = s1_keep[KEEP_W-1-j];
                end
            end
            2'b11: begin
                for (int j = 0; j < KEEP_W; j++) begin
                    for (int b = 0; b < 8; b++) begin
                        xf_data[8*j+b] = s1_data[8*j+7-b];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // S1 register: captures the input beat and its mode whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_keep  <= '0;
            s1_last  <= 1'b0;
            s1_mode  <= 2'b00;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_keep <= in_keep;
                s1_last <= in_last;
                s1_mode <= in_mode;
            end
        end
    end

    // S2 register: holds the transformed beat; contents only change when it is free to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= xf_data;
                out_keep <= xf_keep;
                out_last <= s1_last;
            end
        end
    end

`ifdef STREAM_BIT_REVERSE_STATS_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    // Beat and packet counters; a clear request takes priority over a coincident handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats <= '0;
            stat_pkts  <= '0;
        end else if (stat_clr) begin
            stat_beats <= '0;
            stat_pkts  <= '0;
        end else if (out_fire) begin
            stat_beats <= stat_beats + 32'd1;
            if (out_last) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_bit_reverse.sv
// Testbench for stream_bit_reverse (DATA_W=64): directed checks of the documented
// transform values, latency, back-pressure and reset, then a randomized run compared
// against a queue-based reference model. Stats checks build when
// STREAM_BIT_REVERSE_STATS_EN is defined.
module tb_stream_bit_reverse;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
`ifdef STREAM_BIT_REVERSE_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_beats;
    logic [31:0] stat_pkts;
`endif

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  mon_en = 1'b0;

    logic        hold_prev = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    stream_bit_reverse #(.DATA_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
`ifdef STREAM_BIT_REVERSE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_beats(stat_beats),
        .stat_pkts (stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    // Reference transform written with streaming operators.
    function automatic beat_t model(input logic [63:0] d, input logic [7:0] k,
                                    input logic l, input logic [1:0] m);
        beat_t       r;
        logic [63:0] rev;
        rev    = {<<{d}};
        r.last = l;
        case (m)
            2'b00:   begin r.data = d;         r.keep = k;       end
            2'b01:   begin r.data = rev;       r.keep = {<<{k}}; end
            2'b10:   begin r.data = {<<8{d}};  r.keep = {<<{k}}; end
            default: begin r.data = {<<8{rev}}; r.keep = k;      end
        endcase
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; record accepted beats at the falling edge.
    task automatic apply_stimulus(input logic v, input logic [63:0] d, input logic [7:0] k,
                                  input logic l, input logic [1:0] m, input logic ordy,
                                  output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_keep   = k;
        in_last   = l;
        in_mode   = m;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(d, k, l, m));
    endtask

    task automatic idle(input logic ordy);
        logic a;
        apply_stimulus(1'b0, 64'h0, 8'h0, 1'b0, 2'b00, ordy, a);
    endtask

    // Output monitor: scoreboard every output handshake and check that stalled outputs hold.
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_output("hold_valid", 64'(out_valid), 64'(1));
                check_output("hold_data", out_data, prev_data);
                check_output("hold_keep", 64'(out_keep), 64'(prev_keep));
                check_output("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                check_output("queue_nonempty", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_output("sb_data", out_data, e.data);
                    check_output("sb_keep", 64'(out_keep), 64'(e.keep));
                    check_output("sb_last", 64'(out_last), 64'(e.last));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [63:0] WORD = 64'h0123456789ABCDEF;

    initial begin
        logic        acc;
        logic [63:0] a_d, d_d;
        logic [1:0]  modes [4];
        logic [7:0]  keeps [4];
        logic [63:0] exp_d [4];
        logic [7:0]  exp_k [4];
        int          acc_cnt;
        int          cyc;

        modes = '{2'b10, 2'b11, 2'b01, 2'b01};
        keeps = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
        exp_d = '{64'hEFCDAB8967452301, 64'h80C4A2E691D5B3F7,
                  64'hF7B3D591E6A2C480, 64'hF7B3D591E6A2C480};
        exp_k = '{8'hFF, 8'hFF, 8'hFF, 8'hF0};

        rst_n = 1'b1;
        in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; in_mode = 2'b00;
        out_ready = 1'b0;
`ifdef STREAM_BIT_REVERSE_STATS_EN
        stat_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #11;
        $display("[TB] reset state");
        check_output("rst_out_valid", 64'(out_valid), 64'(0));
        check_output("rst_out_data", out_data, 64'h0);
        check_output("rst_out_keep", 64'(out_keep), 64'(0));
        check_output("rst_out_last", 64'(out_last), 64'(0));
`ifdef STREAM_BIT_REVERSE_STATS_EN
        check_output("rst_stat_beats", 64'(stat_beats), 64'(0));
        check_output("rst_stat_pkts", 64'(stat_pkts), 64'(0));
`endif
        @(posedge clk); #3 rst_n = 1'b1;
        mon_en = 1'b1;
        idle(1'b1);
        check_output("in_ready_after_reset", 64'(in_ready), 64'(1));

        $display("[TB] directed transform values and latency");
        for (int t = 0; t < 4; t++) begin
            apply_stimulus(1'b1, WORD, keeps[t], 1'b1, modes[t], 1'b1, acc);
            check_output("dir_accept", 64'(acc), 64'(1));
            idle(1'b1);
            check_output("dir_not_yet_valid", 64'(out_valid), 64'(0));
            idle(1'b1);
            check_output("dir_valid", 64'(out_valid), 64'(1));
            check_output("dir_data", out_data, exp_d[t]);
            check_output("dir_keep", 64'(out_keep), 64'(exp_k[t]));
        end
        idle(1'b1);

        $display("[TB] back-pressure");
        a_d = {$urandom, $urandom};
        apply_stimulus(1'b1, a_d, 8'hFF, 1'b0, 2'b11, 1'b0, acc);
        check_output("bp_accept_1", 64'(acc), 64'(1));
        apply_stimulus(1'b1, {$urandom, $urandom}, 8'h3C, 1'b0, 2'b10, 1'b0, acc);
        check_output("bp_accept_2", 64'(acc), 64'(1));
        apply_stimulus(1'b1, {$urandom, $urandom}, 8'hA5, 1'b1, 2'b01, 1'b0, acc);
        check_output("bp_in_ready_full", 64'(in_ready), 64'(0));
        check_output("bp_head_data", out_data, model(a_d, 8'hFF, 1'b0, 2'b11).data);
        cyc = 0;
        while (!acc && cyc < 4) begin
            apply_stimulus(1'b1, in_data, in_keep, in_last, in_mode, 1'b1, acc);
            cyc++;
        end
        check_output("bp_accept_3", 64'(acc), 64'(1));
        repeat (4) idle(1'b1);
        check_output("bp_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] reset with beats in flight");
        apply_stimulus(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0, 2'b00, 1'b0, acc);
        apply_stimulus(1'b1, {$urandom, $urandom}, 8'hFF, 1'b1, 2'b00, 1'b0, acc);
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("midrst_out_valid", 64'(out_valid), 64'(0));
        check_output("midrst_out_data", out_data, 64'h0);
        #4 rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);
        check_output("postrst_no_output", 64'(out_valid), 64'(0));
        d_d = {$urandom, $urandom};
        apply_stimulus(1'b1, d_d, 8'hFF, 1'b1, 2'b10, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);
        check_output("postrst_first_valid", 64'(out_valid), 64'(1));
        check_output("postrst_first_data", out_data, {<<8{d_d}});
        idle(1'b1);

        $display("[TB] randomized run");
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 1000 && cyc < 20000) begin
            apply_stimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                           1'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), acc);
            if (acc) acc_cnt++;
            cyc++;
        end
        check_output("rand_accepted", 64'(acc_cnt), 64'(1000));
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            idle(1'b1);
            cyc++;
        end
        check_output("rand_drained", 64'(exp_q.size()), 64'(0));

`ifdef STREAM_BIT_REVERSE_STATS_EN
        $display("[TB] statistics");
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 4; b++) begin
                apply_stimulus(1'b1, {$urandom, $urandom}, 8'hFF, 1'(b == 3), 2'($urandom), 1'b1, acc);
            end
        end
        repeat (3) idle(1'b1);
        check_output("stat_beats_20", 64'(stat_beats), 64'(20));
        check_output("stat_pkts_5", 64'(stat_pkts), 64'(5));
        apply_stimulus(1'b1, {$urandom, $urandom}, 8'hFF, 1'b1, 2'b00, 1'b0, acc);
        idle(1'b0);
        idle(1'b0);
        check_output("stat_stalled_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        stat_clr  = 1'b1;
        @(posedge clk); #1;
        stat_clr  = 1'b0;
        check_output("stat_clr_beats", 64'(stat_beats), 64'(0));
        check_output("stat_clr_pkts", 64'(stat_pkts), 64'(0));
        idle(1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
